alu_host_bridge: RTL and testbench
==================================

# alu_host_bridge

Word-level front end for the byte-serial FP32 add/subtract ALU. It accepts one 32-bit operand pair plus opcode per transaction on a valid/ready slave port, and serialises it onto the ALU's 8-bit bus: start pulse, then A then B, LSB first. It collects the four result bytes and returns the 32-bit result on a valid/ready master port. It sits directly upstream of the ALU and shares its clock and reset.

## Interface
- `TIMEOUT`, default 8: maximum consecutive WAIT_DONE cycles before the transaction is aborted with an error. Legal range 2..255.
- `clk`  in  1  clock; the single clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `s_valid`  in  1  operand request valid.
- `s_ready`  out  1  bridge can accept a request.
- `s_a`  in  32  operand A, IEEE-754 single.
- `s_b`  in  32  operand B, IEEE-754 single.
- `s_op`  in  1  0 = A+B, 1 = A−B.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  consumer accepts the result.
- `m_result`  out  32  result word.
- `m_error`  out  1  qualifies `m_valid`; 1 = timeout abort.
- `alu_start`  out  1  start pulse to the ALU.
- `alu_in`  out  8  operand byte to the ALU.
- `alu_opcode`  out  1  opcode to the ALU.
- `alu_done`  in  1  ALU done flag.
- `alu_out`  in  8  ALU result byte.

## Operation
- States: IDLE, START, SEND, WAIT_DONE, COLLECT, RESP. Use a 3-bit byte index `idx` and an 8-bit watchdog count `wd`.
- IDLE: `s_ready`=1. When `s_valid`&`s_ready` at a clock edge:
  - latch `s_a`, `s_b` and `s_op`;
  - go to START.
- START, one cycle:
  - `alu_start`=1 and `alu_in`=0x00;
  - go to SEND with `idx`=0.
- SEND, 8 cycles: `alu_in` = byte `idx` of the concatenation {B,A}.
  - Order is A[7:0], A[15:8], A[23:16], A[31:24], B[7:0], B[15:8], B[23:16], B[31:24].
  - After `idx`=7, go to WAIT_DONE with `wd`=0.
- WAIT_DONE:
  - if `alu_done`=1, go to COLLECT with `idx`=0;
  - else increment `wd`;
  - if `wd` reaches TIMEOUT−1 without `alu_done`, go to RESP with `m_error`=1 and the result register cleared to 0.
- COLLECT, 4 cycles: at each edge, result[8·idx +: 8] ← `alu_out`. After `idx`=3, go to RESP with `m_error`=0.
- RESP:
  - `m_valid`=1;
  - `m_result` and `m_error` are held stable until `m_valid`&`m_ready`, then go to IDLE;
  - `m_ready` may be held high in advance.
- `alu_opcode` is driven from the latched op and holds from START through RESP. In IDLE it holds the last latched value.
- `alu_start` is 0 in every state except START. `alu_in` is 0x00 outside SEND.
- `s_ready`=1 only in IDLE. No second request is accepted while a transaction is in flight, and there is no overlap.
- `alu_done` is ignored outside WAIT_DONE. A done that is already high on entry to WAIT_DONE is accepted in the first WAIT_DONE cycle.
- Reset (asynchronous, any state, including mid-SEND or mid-COLLECT):
  - state=IDLE, `idx`=0, `wd`=0;
  - operand and result registers = 0;
  - `m_valid`=0, `m_error`=0, `m_result`=0, `alu_start`=0, `alu_in`=0x00, `alu_opcode`=0;
  - `s_ready`=1 once out of reset.
  - Any partial transaction is discarded with no response.

## Timing
- Call the accept edge the end of cycle 0. Then:
  - START is cycle 1;
  - SEND is cycles 2–9;
  - WAIT_DONE covers cycles 10–11, with the ALU asserting done in cycle 11;
  - COLLECT samples `alu_out` at the ends of cycles 12, 13, 14 and 15 (bytes 0–3);
  - `m_valid` rises in cycle 16.
- Latency from accept to `m_valid` is 16 cycles. With `m_ready` held high, the next accept is possible in cycle 17, so throughput is one transaction per 17 cycles.
- All outputs are registered or decoded from the state register only, with no combinational path from inputs to outputs.
- `alu_done` is sampled one cycle before the first result byte. The bridge counts cycles for the bytes and never re-qualifies them with `alu_done`, because done may fall before the last byte is sampled.
- Timeout: `m_valid` with `m_error`=1 appears TIMEOUT+1 cycles after the last SEND cycle.

## Test plan
- Add: A=0x3F800000, B=0x40000000, op=0. Required:
  - `alu_in` sequence 00,00,80,3F,00,00,00,40 in cycles 2–9;
  - `alu_start`=1 only in cycle 1;
  - `m_result`=0x40400000, `m_error`=0, `m_valid` in cycle 16.
- Subtract: A=0x40400000, B=0x3F800000, op=1. Required: `alu_opcode`=1 throughout the transaction, and `m_result`=0x40000000.
- Backpressure: `m_ready` held 0 for 5 cycles after `m_valid`. Required: `m_result` and `m_valid` stable, `s_ready`=0, and IDLE is re-entered exactly one cycle after `m_ready` rises.
- Back-to-back: `s_valid` held high with two pairs (1.0+2.0, then 2.0−1.0) and `m_ready`=1. Required: results 0x40400000 then 0x40000000, with accepts in cycles 0 and 17.
- Timeout: the ALU model holds `alu_done`=0. Required: `m_valid`=1, `m_error`=1, `m_result`=0 in cycle 10+TIMEOUT, after which the bridge returns to IDLE.
- Reset mid-SEND: `rst_n` pulsed low in cycle 5. Required: all outputs immediately take their reset values, no `m_valid`, and a following 1.0+2.0 request yields 0x40400000.

Source files
------------

// File: rtl/alu_host_bridge_if.sv
// Bundle of the host-side request/response handshake and the byte-serial ALU bus
// seen by alu_host_bridge. The bridge connects through the slave modport.
interface alu_host_bridge_if;
  // Both host ports use valid/ready: a beat transfers on a clock edge where valid
  // and ready are both 1. Once raised, valid and its payload hold until that edge.
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_a;
  logic [31:0] s_b;
  logic        s_op;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_result;
  logic        m_error;
  logic        alu_start;
  logic [7:0]  alu_in;
  logic        alu_opcode;
  logic        alu_done;
  logic [7:0]  alu_out;

  modport slave (
    input  s_valid, s_a, s_b, s_op, m_ready, alu_done, alu_out,
    output s_ready, m_valid, m_result, m_error, alu_start, alu_in, alu_opcode
  );

  modport master (
    output s_valid, s_a, s_b, s_op, m_ready, alu_done, alu_out,
    input  s_ready, m_valid, m_result, m_error, alu_start, alu_in, alu_opcode
  );
endinterface

// File: rtl/alu_host_bridge.sv
// Word-level front end for the byte-serial FP32 add/sub ALU: serialises an operand
// pair onto the 8-bit ALU bus and gathers the four result bytes into one word.
module alu_host_bridge #(
  parameter int TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_host_bridge_if.slave    bus,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    SEND      = 3'd2,
    WAIT_DONE = 3'd3,
    COLLECT   = 3'd4,
    RESP      = 3'd5
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  wd_q, wd_d;
  logic [63:0] ops_q, ops_d;      // {B, A}: byte idx is the idx-th byte sent
  logic        op_q, op_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wd_d     = wd_q;
    ops_d    = ops_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.s_valid) begin
          ops_d   = {bus.s_b, bus.s_a};
          op_d    = bus.s_op;
          state_d = START;
        end
      end
      START: begin
        idx_d   = 3'd0;
        state_d = SEND;
      end
      SEND: begin
        if (idx_q == 3'd7) begin
          wd_d    = 8'd0;
          state_d = WAIT_DONE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      WAIT_DONE: begin
        if (bus.alu_done) begin
          idx_d   = 3'd0;
          state_d = COLLECT;
        end else if (wd_q == WD_LAST) begin
          result_d = 32'h0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      COLLECT: begin
        // Bytes arrive LSB first, so shifting in from the top leaves byte 0 at [7:0]
        // after four cycles. alu_done is deliberately not rechecked here.
        result_d = {bus.alu_out, result_q[31:8]};
        if (idx_q == 3'd3) begin
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      RESP: begin
        if (bus.m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      wd_q     <= 8'd0;
      ops_q    <= 64'h0;
      op_q     <= 1'b0;
      result_q <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wd_q     <= wd_d;
      ops_q    <= ops_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Every output is a decode of flops only; no input reaches an output combinationally.
  assign bus.s_ready    = (state_q == IDLE);
  assign bus.m_valid    = (state_q == RESP);
  assign bus.m_result   = result_q;
  assign bus.m_error    = err_q;
  assign bus.alu_start  = (state_q == START);
  assign bus.alu_opcode = op_q;
  assign bus.alu_in     = (state_q == SEND) ? ops_q[{idx_q, 3'b000} +: 8] : 8'h00;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_alu_host_bridge.sv
// Cycle-exact bench for alu_host_bridge: a behavioural ALU and host drive each
// transaction, and every output is compared against values derived from the operands.
module tb_alu_host_bridge;

  localparam int TO = 8;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         n_checks;
  int         n_fail;
  logic [31:0] exp_q[$];

  alu_host_bridge_if bus ();

  alu_host_bridge #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [63:0] w, input int i);
    return 8'(w >> (8 * i));
  endfunction

  // ALU behaviour: known FP32 sums/differences, otherwise an arbitrary result word.
  function automatic logic [31:0] alu_word(input logic [31:0] a, input logic [31:0] b,
                                           input logic op);
    if (a == 32'h3F800000 && b == 32'h40000000 && op == 1'b0) return 32'h40400000;
    if (a == 32'h40400000 && b == 32'h3F800000 && op == 1'b1) return 32'h40000000;
    if (a == 32'h40000000 && b == 32'h3F800000 && op == 1'b1) return 32'h3F800000;
    return $urandom;
  endfunction

  task automatic idle_inputs();
    bus.s_valid  = 1'b0;
    bus.s_a      = 32'h0;
    bus.s_b      = 32'h0;
    bus.s_op     = 1'b0;
    bus.m_ready  = 1'b0;
    bus.alu_done = 1'b0;
    bus.alu_out  = 8'h00;
  endtask

  // Entered at the start of cycle 0 (accept cycle); returns in the first IDLE cycle
  // after the response handshake, whose index is end_cyc.
  // d: WAIT_DONE cycles before done (d >= TO never raises done).
  // bp: cycles m_ready is held low once m_valid is up. early: m_ready high from cycle 0.
  // hold: keep s_valid high with junk payload while the transaction is in flight.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input int d, input int bp, input bit early, input bit hold,
                         output int end_cyc);
    logic [63:0] ops;
    logic [31:0] w;
    logic        exp_err;
    bit          timeout;
    int          r;
    ops     = {b, a};
    timeout = (d >= TO);
    w       = alu_word(a, b, op);
    if (timeout) begin
      r = 10 + TO;
      exp_q.push_back(32'h0);
      exp_err = 1'b1;
    end else begin
      r = 15 + d;
      exp_q.push_back(w);
      exp_err = 1'b0;
    end
    end_cyc = r + bp + 1;

    check("idle_s_ready", bus.s_ready, 1);
    check("idle_m_valid", bus.m_valid, 0);
    bus.s_valid  = 1'b1;
    bus.s_a      = a;
    bus.s_b      = b;
    bus.s_op     = op;
    bus.m_ready  = early ? 1'b1 : 1'($urandom);
    bus.alu_done = 1'($urandom);
    bus.alu_out  = 8'($urandom);

    for (int c = 1; c <= end_cyc; c++) begin
      step();
      check("alu_start", bus.alu_start, (c == 1));
      check("alu_in", bus.alu_in, (c >= 2 && c <= 9) ? byte_of(ops, c - 2) : 8'h00);
      check("alu_opcode", bus.alu_opcode, op);
      if (c < r) begin
        check("m_valid_early", bus.m_valid, 0);
        check("s_ready_busy", bus.s_ready, 0);
      end else if (c < end_cyc) begin
        check("m_valid_resp", bus.m_valid, 1);
        check("m_result", bus.m_result, exp_q[0]);
        check("m_error", bus.m_error, exp_err);
        check("s_ready_resp", bus.s_ready, 0);
      end else begin
        check("m_valid_after", bus.m_valid, 0);
        check("s_ready_after", bus.s_ready, 1);
        void'(exp_q.pop_front());
      end

      if (c < end_cyc) begin
        bus.s_valid = hold;
        bus.s_a     = $urandom;
        bus.s_b     = $urandom;
        bus.s_op    = 1'($urandom);
        if (!timeout && c >= 10 && c <= 10 + d) bus.alu_done = (c == 10 + d);
        else if (timeout && c >= 10 && c < 10 + TO) bus.alu_done = 1'b0;
        else bus.alu_done = 1'($urandom);
        if (!timeout && c >= 11 + d && c <= 14 + d) bus.alu_out = byte_of({32'h0, w}, c - 11 - d);
        else bus.alu_out = 8'($urandom);
        if (early) bus.m_ready = 1'b1;
        else if (c < r) bus.m_ready = 1'($urandom);
        else if (c < r + bp) bus.m_ready = 1'b0;
        else bus.m_ready = 1'b1;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_valid"}, bus.m_valid, 0);
    check({tag, "_m_error"}, bus.m_error, 0);
    check({tag, "_m_result"}, bus.m_result, 0);
    check({tag, "_alu_start"}, bus.alu_start, 0);
    check({tag, "_alu_in"}, bus.alu_in, 0);
    check({tag, "_alu_opcode"}, bus.alu_opcode, 0);
  endtask

  initial begin
    int cyc;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle_inputs();

    #2;
    check_reset_outputs("por");
    step();
    step();
    rst_n = 1'b1;
    step();
    check("por_s_ready", bus.s_ready, 1);
    check("por_m_valid", bus.m_valid, 0);

    // Directed add, m_ready held high in advance.
    run_txn(32'h3F800000, 32'h40000000, 1'b0, 1, 0, 1'b1, 1'b0, cyc);
    idle_inputs();
    step();

    // Directed subtract with five cycles of backpressure.
    run_txn(32'h40400000, 32'h3F800000, 1'b1, 1, 5, 1'b0, 1'b0, cyc);
    idle_inputs();
    step();

    // Back-to-back with s_valid held high throughout.
    run_txn(32'h3F800000, 32'h40000000, 1'b0, 1, 0, 1'b1, 1'b1, cyc);
    check("b2b_second_accept_cycle", cyc, 17);
    run_txn(32'h40400000, 32'h3F800000, 1'b1, 1, 0, 1'b1, 1'b1, cyc);
    check("b2b_second_return_cycle", cyc, 17);
    idle_inputs();
    step();

    // Watchdog abort: done never rises.
    run_txn(32'h40000000, 32'h3F800000, 1'b1, TO, 0, 1'b0, 1'b0, cyc);
    check("timeout_return_cycle", cyc, 10 + TO + 1);
    idle_inputs();
    step();

    // Done already high on WAIT_DONE entry, and done on the very last allowed cycle.
    run_txn($urandom, $urandom, 1'b0, 0, 1, 1'b0, 1'b0, cyc);
    run_txn($urandom, $urandom, 1'b1, TO - 1, 2, 1'b0, 1'b1, cyc);
    idle_inputs();
    step();

    for (int i = 0; i < 8; i++) begin
      int  d;
      int  bp;
      bit  early;
      d     = $urandom_range(0, TO);
      bp    = $urandom_range(0, 3);
      early = (bp == 0) && 1'($urandom);
      run_txn($urandom, $urandom, 1'($urandom), d, bp, early, 1'($urandom), cyc);
      if ($urandom_range(0, 1) == 1) begin
        idle_inputs();
        step();
      end
    end
    idle_inputs();
    step();

    // Leave op=1 and a nonzero result so the reset values below are distinguishable.
    run_txn(32'h40400000, 32'h3F800000, 1'b1, 1, 0, 1'b0, 1'b0, cyc);
    idle_inputs();

    // Reset mid-SEND: accept 1.0+2.0, pull rst_n low in cycle 5.
    bus.s_valid = 1'b1;
    bus.s_a     = 32'h3F800000;
    bus.s_b     = 32'h40000000;
    bus.s_op    = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      bus.s_valid = 1'b0;
    end
    check("pre_reset_alu_in", bus.alu_in, 8'h3F);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    step();
    check_reset_outputs("mid_rst_hold");
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      check("post_rst_m_valid", bus.m_valid, 0);
      check("post_rst_alu_start", bus.alu_start, 0);
      check("post_rst_s_ready", bus.s_ready, 1);
    end
    run_txn(32'h3F800000, 32'h40000000, 1'b0, 1, 0, 1'b0, 1'b0, cyc);
    idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
